pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, meaning framebuffer height in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning pixel queue entries (power of 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port x, input, 10, pixel column from draw_mux.
REQ-007 SHALL have port y, input, 10, pixel row from draw_mux.
REQ-008 SHALL have port colour, input, 3, pixel RGB.
REQ-009 SHALL have port writeEn, input, 1, pixel valid this cycle (no back-pressure upstream).
REQ-010 SHALL have port clear, input, 1, one-cycle request to blank the whole framebuffer.
REQ-011 SHALL have port fb_ready, input, 1, framebuffer accepts the write this cycle.
REQ-012 SHALL have port fb_addr, output, 15, linear framebuffer address.
REQ-013 SHALL have port fb_data, output, 3, colour written.
REQ-014 SHALL have port fb_we, output, 1, write valid; a transfer occurs when fb_we and fb_ready are both 1.
REQ-015 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-016 SHALL have port busy, output, 1, clear in progress.
REQ-017 SHALL have port drop_count, output, 8, count of discarded input pixels.

Function
REQ-018 SHALL compute address = y*SCREEN_W + x at push time and store the 15-bit address plus 3-bit colour per FIFO entry.
REQ-019 SHALL push on writeEn when x<SCREEN_W, y<SCREEN_H, full=0, and no clear in the same cycle.
REQ-020 SHALL discard, and increment drop_count (saturating at 255), any writeEn pixel that is out of bounds, arrives while full, or arrives in a clear cycle.
REQ-021 SHALL evaluate full from the registered count; a push while full is rejected even when a pop occurs in the same cycle.
REQ-022 SHALL allow simultaneous push and pop when not full, leaving count unchanged.
REQ-023 SHALL provide no bypass: a pixel pushed in cycle N drives fb_addr/fb_data with fb_we=1 no earlier than cycle N+1.
REQ-024 SHALL implement states RUN and CLEAR.
REQ-025 In RUN, fb_we SHALL equal FIFO non-empty; fb_addr/fb_data SHALL show the FIFO head; pop occurs on fb_ready.
REQ-026 In RUN, fb_addr/fb_data SHALL hold stable while fb_we=1 and fb_ready=0.
REQ-027 A clear pulse in RUN SHALL flush the FIFO, zero the sweep counter and enter CLEAR next cycle.
REQ-028 In CLEAR, outputs SHALL be fb_we=1, fb_data=000, fb_addr=sweep counter, busy=1; the counter SHALL advance only on fb_ready.
REQ-029 CLEAR SHALL return to RUN on the cycle after the transfer at address SCREEN_W*SCREEN_H-1, with busy=0 in that cycle.
REQ-030 In CLEAR, pixels SHALL still be pushed per REQ-019 and written after returning to RUN; the FIFO SHALL NOT pop during CLEAR.
REQ-031 A clear pulse received while in CLEAR SHALL be ignored for state purposes (the sweep does not restart), but a same-cycle pixel is still dropped.

Reset
REQ-032 On reset SHALL set state=RUN, FIFO empty, fb_we=0, fb_addr=0, fb_data=0, full=0, busy=0, drop_count=0.
REQ-033 Reset during CLEAR SHALL abort the sweep with no further writes.
REQ-034 Reset SHALL take priority over clear and writeEn in the same cycle.

Structure
REQ-035 SHALL place SCREEN_W/SCREEN_H defaults, FB_ADDR_W=15, COLOUR_W=3 and BLACK=3'b000 in the shared package.
REQ-036 SHALL instantiate one sub-module, pixel_fifo: a synchronous show-ahead FIFO with push, pop, flush, full and empty.

Verification
REQ-037 SHALL cover this scenario: push (x=3,y=2,colour=101) with fb_ready=1 -> next cycle fb_we=1, fb_addr=323, fb_data=101; drop_count=0.
REQ-038 SHALL cover this scenario: push x=160,y=0 then x=0,y=120 -> no fb_we, drop_count=2.
REQ-039 SHALL cover this scenario: fb_ready=0 and 10 in-bounds pushes -> full=1 after 8, drop_count=2; then fb_ready=1 -> 8 writes in push order, head held stable while stalled.
REQ-040 SHALL cover this scenario: 3 queued pixels then a clear pulse -> queue flushed, exactly 19200 writes of 000 at addresses 0..19199, busy=1 throughout, then busy=0.
REQ-041 SHALL cover this scenario: 2 pushes during CLEAR with fb_ready toggling -> both pixels written after address 19199 completes, with correct addresses.
REQ-042 SHALL cover this scenario: reset asserted mid-CLEAR at address 500 -> next cycle fb_we=0, busy=0, drop_count=0, FIFO empty.

Source files
------------

// File: rtl/pixel_writer_pkg.sv
// Shared types and constants for the pixel writer: framebuffer geometry,
// queued pixel format and the writer's top-level states.
package pixel_writer_pkg;

    localparam int DEFAULT_SCREEN_W = 160;
    localparam int DEFAULT_SCREEN_H = 120;
    localparam int FB_ADDR_W        = 15;
    localparam int COLOUR_W         = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

    typedef enum logic {
        ST_RUN,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [COLOUR_W-1:0]  colour;
    } pixel_t;

    // Only meaningful for in-bounds coordinates, where the product fits in FB_ADDR_W bits.
    function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [9:0] px,
                                                         input logic [9:0] py,
                                                         input int         width);
        return FB_ADDR_W'(py) * FB_ADDR_W'(width) + FB_ADDR_W'(px);
    endfunction

endpackage

// File: rtl/pixel_writer_fifo.sv
// Synchronous show-ahead FIFO holding queued pixels; the head entry is
// visible on rd_data whenever empty is low.
module pixel_fifo
    import pixel_writer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  pixel_t wr_data,
    output pixel_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    pixel_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pixel_writer.sv
// Queues drawn pixels and streams them to the framebuffer, and sweeps the
// whole framebuffer to black on a clear request.
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int SCREEN_W   = DEFAULT_SCREEN_W,
    parameter int SCREEN_H   = DEFAULT_SCREEN_H,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic [COLOUR_W-1:0]  colour,
    input  logic                 writeEn,
    input  logic                 clear,
    input  logic                 fb_ready,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [COLOUR_W-1:0]  fb_data,
    output logic                 fb_we,
    output logic                 full,
    output logic                 busy,
    output logic [7:0]           drop_count
);

    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

    state_t               state;
    state_t               next_state;
    logic [FB_ADDR_W-1:0] sweep;
    logic                 in_bounds;
    logic                 push;
    logic                 pop;
    logic                 clear_start;
    logic                 empty;
    pixel_t               new_pixel;
    pixel_t               head;

    assign in_bounds   = (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H));
    // A clear pulse drops its same-cycle pixel even when it is ignored during a sweep.
    assign push        = writeEn && in_bounds && !full && !clear;
    assign clear_start = (state == ST_RUN) && clear;
    assign pop         = (state == ST_RUN) && fb_ready && !empty;
    assign new_pixel   = '{addr: pixel_addr(x, y, SCREEN_W), colour: colour};

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (clear_start),
        .wr_data (new_pixel),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:   if (clear) next_state = ST_CLEAR;
            ST_CLEAR: if (fb_ready && sweep == LAST_ADDR) next_state = ST_RUN;
            default:  next_state = ST_RUN;
        endcase
    end

    always_comb begin
        fb_we   = 1'b0;
        fb_addr = '0;
        fb_data = BLACK;
        busy    = 1'b0;
        case (state)
            ST_RUN: begin
                if (!empty) begin
                    fb_we   = 1'b1;
                    fb_addr = head.addr;
                    fb_data = head.colour;
                end
            end
            ST_CLEAR: begin
                fb_we   = 1'b1;
                fb_addr = sweep;
                fb_data = BLACK;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear_start) begin
            sweep <= '0;
        end else if (state == ST_CLEAR && fb_ready && sweep != LAST_ADDR) begin
            sweep <= sweep + FB_ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (writeEn && !push && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed self-checking bench for pixel_writer at its default geometry
// (160x120 framebuffer, 8-entry queue).
module tb_pixel_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [2:0]  colour = '0;
    logic        writeEn = 1'b0;
    logic        clear = 1'b0;
    logic        fb_ready = 1'b0;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        full;
    logic        busy;
    logic [7:0]  drop_count;

    int checks = 0;
    int failures = 0;

    pixel_writer dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .clear      (clear),
        .fb_ready   (fb_ready),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .full       (full),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        writeEn = 1'b0;
        clear = 1'b0;
        fb_ready = 1'b0;
        x = '0;
        y = '0;
        colour = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        writeEn = 1'b1;
        clear = 1'b1;
        fb_ready = 1'b1;
        x = 10'd5;
        y = 10'd5;
        colour = 3'd7;
        tick();
        tick();
        reset = 1'b0;
        writeEn = 1'b0;
        clear = 1'b0;
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_fb_we: got %0b expected 0", fb_we); end
        checks++; if (fb_addr !== 15'd0) begin failures++; $display("[TB] FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
        checks++; if (fb_data !== 3'b000) begin failures++; $display("[TB] FAIL reset_fb_data: got %b expected 000", fb_data); end
        checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %0b expected 0", full); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_drop_count: got %0d expected 0", drop_count); end
        tick();
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_priority_no_write: got %0b expected 0", fb_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_priority_no_clear: got %0b expected 0", busy); end
    endtask

    task automatic test_single_pixel();
        do_reset();
        fb_ready = 1'b1;
        x = 10'd3;
        y = 10'd2;
        colour = 3'b101;
        writeEn = 1'b1;
        #1;
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL single_no_bypass: got fb_we=%0b expected 0", fb_we); end
        tick();
        writeEn = 1'b0;
        checks++; if (fb_we !== 1'b1) begin failures++; $display("[TB] FAIL single_fb_we: got %0b expected 1", fb_we); end
        checks++; if (fb_addr !== 15'd323) begin failures++; $display("[TB] FAIL single_fb_addr: got %0d expected 323", fb_addr); end
        checks++; if (fb_data !== 3'b101) begin failures++; $display("[TB] FAIL single_fb_data: got %b expected 101", fb_data); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("[TB] FAIL single_drop_count: got %0d expected 0", drop_count); end
        tick();
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL single_popped: got fb_we=%0b expected 0", fb_we); end
    endtask

    task automatic test_out_of_bounds();
        do_reset();
        fb_ready = 1'b1;
        writeEn = 1'b1;
        x = 10'd160;
        y = 10'd0;
        tick();
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL oob_x_no_write: got %0b expected 0", fb_we); end
        x = 10'd0;
        y = 10'd120;
        tick();
        writeEn = 1'b0;
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL oob_y_no_write: got %0b expected 0", fb_we); end
        checks++; if (drop_count !== 8'd2) begin failures++; $display("[TB] FAIL oob_drop_count: got %0d expected 2", drop_count); end
    endtask

    task automatic test_full();
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            x = 10'(i);
            y = 10'd1;
            colour = 3'(i);
            writeEn = 1'b1;
            tick();
            checks++;
            if (full !== logic'(i >= 7)) begin
                failures++;
                $display("[TB] FAIL full_after_push%0d: got %0b expected %0b", i, full, (i >= 7));
            end
        end
        writeEn = 1'b0;
        checks++; if (drop_count !== 8'd2) begin failures++; $display("[TB] FAIL full_drop_count: got %0d expected 2", drop_count); end
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (fb_we !== 1'b1 || fb_addr !== 15'd160 || fb_data !== 3'd0) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d: got we=%0b addr=%0d data=%0d expected we=1 addr=160 data=0", s, fb_we, fb_addr, fb_data);
            end
            tick();
        end
        // First drain cycle also offers a pixel; full is registered so it must be rejected.
        fb_ready = 1'b1;
        writeEn = 1'b1;
        x = 10'd50;
        y = 10'd1;
        colour = 3'd7;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (fb_we !== 1'b1 || fb_addr !== 15'(160 + k) || fb_data !== 3'(k)) begin
                failures++;
                $display("[TB] FAIL drain%0d: got we=%0b addr=%0d data=%0d expected we=1 addr=%0d data=%0d", k, fb_we, fb_addr, fb_data, 160 + k, k % 8);
            end
            tick();
            writeEn = 1'b0;
        end
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL drain_empty: got %0b expected 0", fb_we); end
        checks++; if (drop_count !== 8'd3) begin failures++; $display("[TB] FAIL full_pop_reject_drop: got %0d expected 3", drop_count); end
        checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL drain_full_clear: got %0b expected 0", full); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = 10'(i + 1);
            y = 10'd0;
            colour = 3'(i + 1);
            writeEn = 1'b1;
            tick();
            checks++;
            if (fb_we !== 1'b1 || fb_addr !== 15'(i + 1) || fb_data !== 3'(i + 1) || full !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b%0d: got we=%0b addr=%0d data=%0d full=%0b expected we=1 addr=%0d data=%0d full=0", i, fb_we, fb_addr, fb_data, full, i + 1, i + 1);
            end
        end
        writeEn = 1'b0;
        tick();
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL b2b_empty: got %0b expected 0", fb_we); end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        writeEn = 1'b1;
        x = 10'd0;
        y = 10'd200;
        repeat (300) tick();
        writeEn = 1'b0;
        checks++; if (drop_count !== 8'd255) begin failures++; $display("[TB] FAIL drop_saturate: got %0d expected 255", drop_count); end
    endtask

    task automatic test_clear_sweep();
        int exp_addr;
        int bad;
        int first_bad;
        int guard;
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = 10'(10 + i);
            y = 10'd5;
            colour = 3'd4;
            writeEn = 1'b1;
            tick();
        end
        writeEn = 1'b0;
        checks++; if (fb_we !== 1'b1) begin failures++; $display("[TB] FAIL clear_queue_loaded: got %0b expected 1", fb_we); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        fb_ready = 1'b1;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL clear_busy_start: got %0b expected 1", busy); end
        exp_addr = 0;
        bad = 0;
        first_bad = -1;
        guard = 0;
        while (busy === 1'b1 && guard < 25000) begin
            if (fb_we !== 1'b1 || fb_addr !== 15'(exp_addr) || fb_data !== 3'b000) begin
                if (bad == 0) first_bad = exp_addr;
                bad++;
            end
            exp_addr++;
            guard++;
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL clear_sweep_writes: got %0d bad cycles (first at %0d) expected 0", bad, first_bad); end
        checks++; if (exp_addr != 19200) begin failures++; $display("[TB] FAIL clear_sweep_count: got %0d writes expected 19200", exp_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL clear_busy_end: got %0b expected 0", busy); end
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL clear_flushed: got fb_we=%0b expected 0", fb_we); end
    endtask

    task automatic test_clear_with_pushes();
        int exp_addr;
        int bad;
        int first_bad;
        int k;
        do_reset();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_addr = 0;
        bad = 0;
        first_bad = -1;
        k = 0;
        while (busy === 1'b1 && k < 50000) begin
            fb_ready = (k % 2 == 1);
            writeEn = (k == 5) || (k == 6);
            x = (k == 5) ? 10'd7 : 10'd159;
            y = (k == 5) ? 10'd3 : 10'd119;
            colour = (k == 5) ? 3'd3 : 3'd6;
            if (fb_we !== 1'b1 || fb_addr !== 15'(exp_addr) || fb_data !== 3'b000) begin
                if (bad == 0) first_bad = exp_addr;
                bad++;
            end
            if (fb_ready) exp_addr++;
            tick();
            k++;
        end
        writeEn = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL toggle_sweep_writes: got %0d bad cycles (first at %0d) expected 0", bad, first_bad); end
        checks++; if (exp_addr != 19200) begin failures++; $display("[TB] FAIL toggle_sweep_count: got %0d writes expected 19200", exp_addr); end
        checks++;
        if (busy !== 1'b0 || fb_we !== 1'b1 || fb_addr !== 15'd487 || fb_data !== 3'd3) begin
            failures++;
            $display("[TB] FAIL queued_pixel0: got busy=%0b we=%0b addr=%0d data=%0d expected busy=0 we=1 addr=487 data=3", busy, fb_we, fb_addr, fb_data);
        end
        fb_ready = 1'b1;
        tick();
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 15'd19199 || fb_data !== 3'd6) begin
            failures++;
            $display("[TB] FAIL queued_pixel1: got we=%0b addr=%0d data=%0d expected we=1 addr=19199 data=6", fb_we, fb_addr, fb_data);
        end
        tick();
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL queued_done: got %0b expected 0", fb_we); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("[TB] FAIL queued_drop_count: got %0d expected 0", drop_count); end
    endtask

    task automatic test_reset_mid_clear();
        int exp_addr;
        int bad;
        int k;
        do_reset();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        fb_ready = 1'b1;
        exp_addr = 0;
        bad = 0;
        k = 0;
        while (exp_addr < 500 && k < 2000) begin
            writeEn = (k == 2) || (k == 3);
            clear = (k == 3);
            x = 10'd20;
            y = 10'd4;
            colour = 3'd2;
            if (fb_addr !== 15'(exp_addr) || busy !== 1'b1) bad++;
            exp_addr++;
            tick();
            k++;
        end
        writeEn = 1'b0;
        clear = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL midclear_sweep: got %0d bad cycles expected 0", bad); end
        checks++; if (fb_addr !== 15'd500 || busy !== 1'b1) begin failures++; $display("[TB] FAIL midclear_at500: got addr=%0d busy=%0b expected addr=500 busy=1", fb_addr, busy); end
        checks++; if (drop_count !== 8'd1) begin failures++; $display("[TB] FAIL midclear_drop: got %0d expected 1", drop_count); end
        reset = 1'b1;
        clear = 1'b1;
        writeEn = 1'b1;
        x = 10'd1;
        y = 10'd1;
        tick();
        reset = 1'b0;
        clear = 1'b0;
        writeEn = 1'b0;
        checks++; if (fb_we !== 1'b0) begin failures++; $display("[TB] FAIL abort_fb_we: got %0b expected 0", fb_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %0b expected 0", busy); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("[TB] FAIL abort_drop: got %0d expected 0", drop_count); end
        checks++; if (full !== 1'b0 || fb_addr !== 15'd0) begin failures++; $display("[TB] FAIL abort_outputs: got full=%0b addr=%0d expected full=0 addr=0", full, fb_addr); end
        tick();
        checks++; if (fb_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_fifo_empty: got we=%0b busy=%0b expected we=0 busy=0", fb_we, busy); end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_out_of_bounds();
        test_full();
        test_back_to_back();
        test_drop_saturate();
        test_clear_sweep();
        test_clear_with_pushes();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
